// File: rtl/risc_toy_pkg.sv
// Shared MEM/WB bundle layout and register-file sizing.
// Used by the MEM_WB producer and the write-back/register-file consumer.
package risc_toy_pkg;

  localparam int XLEN   = 32;
  localparam int AW     = 5;
  localparam int NREG   = 1 << AW;
  localparam int CTRL_W = 2;
  localparam int BUND_W = CTRL_W + XLEN + AW;

  localparam int WB_CTRL_MSB = 38;
  localparam int DATA_LSB    = 5;
  localparam int RD_LSB      = 0;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   data;
    logic [AW-1:0]     rd;
  } mem_wb_t;

  function automatic mem_wb_t unpack_mem_wb(
    input logic [BUND_W-1:0] w
  );
    mem_wb_t b;
    b.ctrl = w[WB_CTRL_MSB -: CTRL_W];
    b.data = w[DATA_LSB +: XLEN];
    b.rd   = w[RD_LSB +: AW];
    return b;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Bus between the MEM_WB register / ID stage and the write-back regfile.
// master drives bundle, mem data and read addresses; slave returns reads,
// forward registers and retire count.
interface wb_regfile_if;
  import risc_toy_pkg::*;

  logic [BUND_W-1:0] MEM_WB_in;
  logic [XLEN-1:0]   mem_rdata;
  logic [AW-1:0]     rs1_addr;
  logic [AW-1:0]     rs2_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic              wb_valid;
  logic [AW-1:0]     wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic [31:0]       retire_cnt;

  modport master (
    output MEM_WB_in, mem_rdata, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_valid, wb_rd,
    input  wb_data, retire_cnt
  );

  modport slave (
    input  MEM_WB_in, mem_rdata, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_valid, wb_rd,
    output wb_data, retire_cnt
  );

endinterface

// File: rtl/wb_regfile_rf.sv
// 32x32 two-read one-write register file, r0 reads zero,
// same-cycle write-through bypass; reads forced to zero while RST is high.
module regfile_2r1w
  import risc_toy_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            we_i,
  input  logic [AW-1:0]   wa_i,
  input  logic [XLEN-1:0] wd_i,
  input  logic [AW-1:0]   ra1_i,
  input  logic [AW-1:0]   ra2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic            wr_ok;

  // r0 is never written, even if a caller asserts we_i with wa_i==0
  assign wr_ok = we_i & (wa_i != '0) & ~RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = '0;
    if (!RST && ra1_i != '0) begin
      rd1_o = (wr_ok && wa_i == ra1_i) ? wd_i : regs_q[ra1_i];
    end
  end

  always_comb begin
    rd2_o = '0;
    if (!RST && ra2_i != '0) begin
      rd2_o = (wr_ok && wa_i == ra2_i) ? wd_i : regs_q[ra2_i];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: unpacks MEM_WB, picks the write-back value, commits it,
// keeps a 1-cycle forward copy of the last write and counts retired writes.
module wb_regfile
  import risc_toy_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  wb_regfile_if.slave  bus
);

  mem_wb_t         bnd;
  logic            reg_write;
  logic            mem_to_reg;
  logic [XLEN-1:0] wb_value;
  logic            we;

  logic            valid_q, valid_d;
  logic [AW-1:0]   rd_q,    rd_d;
  logic [XLEN-1:0] data_q,  data_d;
  logic [31:0]     cnt_q,   cnt_d;

  assign bnd        = unpack_mem_wb(bus.MEM_WB_in);
  assign reg_write  = bnd.ctrl[WB_REGWRITE];
  assign mem_to_reg = bnd.ctrl[WB_MEMTOREG];
  assign wb_value   = mem_to_reg ? bus.mem_rdata : bnd.data;
  assign we         = reg_write & (bnd.rd != '0) & ~RST;

  regfile_2r1w u_rf (
    .CLK   (CLK),
    .RST   (RST),
    .we_i  (we),
    .wa_i  (bnd.rd),
    .wd_i  (wb_value),
    .ra1_i (bus.rs1_addr),
    .ra2_i (bus.rs2_addr),
    .rd1_o (bus.rs1_data),
    .rd2_o (bus.rs2_data)
  );

  always_comb begin
    valid_d = we;
    rd_d    = we ? bnd.rd : '0;
    data_d  = we ? wb_value : '0;
    cnt_d   = cnt_q + {31'd0, we};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.wb_valid   = valid_q;
  assign bus.wb_rd      = rd_q;
  assign bus.wb_data    = data_q;
  assign bus.retire_cnt = cnt_q;

endmodule
